// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit_pkg                                                   |
// | Purpose : Shared constants, state encoding and PC helper for the fetch     |
// |           stage (fetch_unit, fetch_unit_pc_reg, fetch_unit_if users).      |
// | Ports   : none (package)                                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Opcode field (instr[15:11]) values the fetch stage cares about.
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_VALID  = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  // Sequential PC step; wraps 16'hFFFE -> 16'h0000 by plain modulo arithmetic.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit_if                                                    |
// | Purpose : Bundles the fetch stage's instruction-memory handshake and its   |
// |           decode-side instruction/control signals.                         |
// | Ports   : master = fetch stage  (drives imem_req/addr, instr*, halted)     |
// |           slave  = environment  (drives imem_ready/rdata, stall, redirect, |
// |                                  redirect_addr, halt)                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        halt;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, pc_plus2, instr_valid, halted,
    input  imem_ready, imem_rdata, stall_in, redirect, redirect_addr, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, pc_plus2, instr_valid, halted,
    output imem_ready, imem_rdata, stall_in, redirect, redirect_addr, halt
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit_pc_reg                                                |
// | Purpose : 16-bit program counter register with load enable.               |
// | Ports   : clk, rst (sync, active high -> RESET_PC)                         |
// |           load_i  - capture d_i on this edge                               |
// |           d_i     - next PC value                                          |
// |           q_o     - current PC                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_unit_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit                                                       |
// | Purpose : Instruction-fetch stage. Owns the PC, fetches one instruction at |
// |           a time over a req/ready memory handshake, holds it for decode   |
// |           until consumed, then applies redirect / halt / PC+2.           |
// | Ports   : clk, rst  - single clock, synchronous active-high reset         |
// |           bus       - fetch_unit_if.master (memory + decode signals)      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = fetch_unit_pkg::RESET_PC,
  parameter logic [15:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  import fetch_unit_pkg::*;

  fetch_state_e state_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic [15:0]  instr_q;
  logic [15:0]  instr_pc_q;
  logic [15:0]  pc_plus2_q;
  logic         halted_q;

  logic [15:0]  pc_q;
  logic         pc_load_d;
  logic [15:0]  pc_next_d;
  logic         consume;

  // instr_valid_q is high exactly in ST_VALID, so it doubles as the state test.
  assign consume = instr_valid_q & ~bus.stall_in;

  // PC only moves when an instruction is consumed; halt freezes it.
  always_comb begin
    pc_load_d = 1'b0;
    pc_next_d = pc_q;
    if (consume && !bus.halt) begin
      pc_load_d = 1'b1;
      pc_next_d = bus.redirect ? (bus.redirect_addr & 16'hFFFE) : pc_inc(pc_q);
    end
  end

  fetch_unit_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load_d),
    .d_i    (pc_next_d),
    .q_o    (pc_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      pc_plus2_q    <= pc_inc(RESET_PC);
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!imem_req_q) begin
            // Only reachable on the first cycle after reset: the request
            // is not yet visible to memory, so ready carries no meaning.
            imem_req_q <= 1'b1;
          end else if (bus.imem_ready) begin
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            pc_plus2_q    <= pc_inc(pc_q);
            state_q       <= ST_VALID;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ready) begin
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            pc_plus2_q    <= pc_inc(pc_q);
            state_q       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (consume) begin
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            if (bus.halt) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALTED;
            end else begin
              // Request goes out together with the new PC, giving the
              // two-cycle fetch/valid rhythm with no idle cycle.
              imem_req_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          instr_q       <= NOP_INSTR;
          halted_q      <= 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus2    = pc_plus2_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_unit                                                    |
// | Purpose : Self-checking bench for fetch_unit: memory responder with a     |
// |           configurable slow address, transaction-level reference model,   |
// |           per-cycle compare and directed scenarios with literal checks.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory image: every address holds a distinct, easily hand-computed word.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        slow_en   = 1'b0;
  logic [15:0] slow_addr = 16'h0000;
  int          slow_wait = 0;
  int          waited    = 0;
  logic [15:0] junk      = 16'hDEAD;

  assign bus.imem_ready = !(slow_en && bus.imem_req && (bus.imem_addr == slow_addr)
                            && (waited < slow_wait));
  // Garbage on rdata whenever ready is low.
  assign bus.imem_rdata = bus.imem_ready ? memf(bus.imem_addr) : junk;

  always @(posedge clk) begin
    junk <= 16'($urandom);
    if (rst || bus.imem_ready) waited <= 0;
    else if (bus.imem_req)     waited <= waited + 1;
  end

  // ---------------- reference model ----------------
  // Phases: UNK before first reset, RST = first cycle after reset (no request
  // yet), REQ = request outstanding at m_pc, VAL = instruction presented,
  // HALT = stopped.
  typedef enum {M_UNK, M_RST, M_REQ, M_VAL, M_HALT} mphase_e;
  mphase_e     ph = M_UNK;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_ipc   = 16'h0000;
  logic [15:0] m_instr = 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      ph   <= M_RST;
      m_pc <= 16'h0000;
    end else begin
      case (ph)
        M_RST: ph <= M_REQ;
        M_REQ: if (bus.imem_ready) begin
          m_ipc   <= m_pc;
          m_instr <= memf(m_pc);
          ph      <= M_VAL;
        end
        M_VAL: if (!bus.stall_in) begin
          if (bus.halt) ph <= M_HALT;
          else begin
            m_pc <= bus.redirect ? (bus.redirect_addr & 16'hFFFE) : m_pc + 16'd2;
            ph   <= M_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (ph != M_UNK) begin
      chk("m_req", 16'(bus.imem_req), 16'(ph == M_REQ));
      if (ph == M_REQ) chk("m_addr", bus.imem_addr, m_pc);
      chk("m_valid", 16'(bus.instr_valid), 16'(ph == M_VAL));
      chk("m_instr", bus.instr, (ph == M_VAL) ? m_instr : NOP);
      if (ph == M_VAL) begin
        chk("m_instr_pc", bus.instr_pc, m_ipc);
        chk("m_pc_plus2", bus.pc_plus2, m_ipc + 16'd2);
      end
      chk("m_halted", 16'(bus.halted), 16'(ph == M_HALT));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.instr_valid !== 1'b1 && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("valid_reached", 16'(bus.instr_valid), 16'd1);
  endtask

  task automatic consume(input logic rd, input logic [15:0] ra, input logic hl);
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.halt          = hl;
    step(1);
    bus.redirect = 1'b0;
    bus.halt     = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: run did not complete, n_bad=%0d", n_bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    int n;
    bus.stall_in      = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 16'h0000;
    bus.halt          = 1'b0;

    // Reset state
    rst = 1'b1;
    step(1);
    chk("rst_req",      16'(bus.imem_req),    16'd0);
    chk("rst_valid",    16'(bus.instr_valid), 16'd0);
    chk("rst_instr",    bus.instr,            16'h0800);
    chk("rst_instr_pc", bus.instr_pc,         16'h0000);
    chk("rst_halted",   16'(bus.halted),      16'd0);
    rst = 1'b0;

    // Free running, ready always 1: sequential addresses, valid every 2nd cycle
    wait_valid(cyc);
    chk("first_pc",    bus.instr_pc, 16'h0000);
    chk("first_instr", bus.instr,    16'h5A3C);
    for (int i = 1; i < 8; i++) begin
      step(1);
      wait_valid(cyc);
      chk("seq_gap", 16'(cyc), 16'd1);
      chk("seq_pc",  bus.instr_pc, 16'(2 * i));
    end

    // Memory stalls 3 cycles at 0x0010: request held 4 cycles
    slow_addr = 16'h0010;
    slow_wait = 3;
    slow_en   = 1'b1;
    step(1);
    n = 0;
    for (int k = 0; k < 20 && bus.instr_valid !== 1'b1; k++) begin
      if (bus.imem_req && bus.imem_addr == 16'h0010) n++;
      step(1);
    end
    chk("wait_hold_cycles", 16'(n), 16'd4);
    chk("wait_instr_pc",    bus.instr_pc, 16'h0010);
    chk("wait_instr",       bus.instr,    16'h4A3C);
    slow_en = 1'b0;

    // Downstream stall for 5 cycles; redirect offered while stalled is ignored
    bus.stall_in      = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("stall_instr",    bus.instr,            16'h4A3C);
      chk("stall_instr_pc", bus.instr_pc,         16'h0010);
      chk("stall_req",      16'(bus.imem_req),    16'd0);
      chk("stall_valid",    16'(bus.instr_valid), 16'd1);
    end
    bus.stall_in = 1'b0;
    bus.redirect = 1'b0;
    step(1);
    chk("after_stall_req",  16'(bus.imem_req), 16'd1);
    chk("after_stall_addr", bus.imem_addr,     16'h0012);

    // Redirect to odd target: bit 0 dropped
    wait_valid(cyc);
    consume(1'b1, 16'h1235, 1'b0);
    chk("redir_addr", bus.imem_addr, 16'h1234);
    wait_valid(cyc);
    chk("redir_instr_pc", bus.instr_pc, 16'h1234);

    // PC wrap at 0xFFFE
    consume(1'b1, 16'hFFFF, 1'b0);
    wait_valid(cyc);
    chk("wrap_instr_pc", bus.instr_pc, 16'hFFFE);
    chk("wrap_pc_plus2", bus.pc_plus2, 16'h0000);
    consume(1'b0, 16'h0000, 1'b0);
    chk("wrap_addr", bus.imem_addr, 16'h0000);

    // Reset while waiting on memory
    wait_valid(cyc);
    slow_addr = 16'h0002;
    slow_wait = 100;
    slow_en   = 1'b1;
    consume(1'b0, 16'h0000, 1'b0);
    step(2);
    chk("wait_pre_rst_req",  16'(bus.imem_req), 16'd1);
    chk("wait_pre_rst_addr", bus.imem_addr,     16'h0002);
    rst = 1'b1;
    step(1);
    chk("wait_rst_req",  16'(bus.imem_req), 16'd0);
    chk("wait_rst_addr", bus.imem_addr,     16'h0000);
    rst     = 1'b0;
    slow_en = 1'b0;
    wait_valid(cyc);
    chk("post_rst_instr_pc", bus.instr_pc, 16'h0000);

    // Halt together with redirect: halt wins, stays halted until reset
    consume(1'b1, 16'h2000, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("halt_req",    16'(bus.imem_req), 16'd0);
      chk("halt_halted", 16'(bus.halted),   16'd1);
    end
    rst = 1'b1;
    step(1);
    chk("halt_rst_halted", 16'(bus.halted), 16'd0);
    rst = 1'b0;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("halt_restart_req",  16'(bus.imem_req), 16'd1);
    chk("halt_restart_addr", bus.imem_addr,     16'h0000);
    wait_valid(cyc);
    chk("halt_restart_instr", bus.instr, 16'h5A3C);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
